// File: rtl/ht_cmd_initiator_pkg.sv
// Shared hash-table command/result payloads and widths for the command initiator.
package hash_table;

    localparam int unsigned LAT_W = 16;
    localparam int unsigned KEY_W = 32;
    localparam int unsigned VAL_W = 32;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_INSERT = 2'd1,
        OP_DELETE = 2'd2,
        OP_CLEAR  = 2'd3
    } ht_opcode_e;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_NOT_FOUND = 2'd1,
        ST_FULL      = 2'd2,
        ST_ERROR     = 2'd3
    } ht_status_e;

    typedef struct packed {
        ht_opcode_e         opcode;
        logic [KEY_W-1:0]   key;
        logic [VAL_W-1:0]   value;
    } ht_command_t;

    typedef struct packed {
        ht_status_e         status;
        logic [VAL_W-1:0]   value;
    } ht_result_t;

    typedef enum logic [1:0] {
        WD_IDLE    = 2'd0,
        WD_WAIT    = 2'd1,
        WD_TIMEOUT = 2'd2
    } wd_state_e;

endpackage

// File: rtl/ht_cmd_initiator_if.sv
// Valid/ready channels between the initiator and the hash table.
interface ht_cmd_if;
    import hash_table::*;

    ht_command_t cmd;
    logic        valid;
    logic        ready;

    modport master (output cmd, output valid, input ready);
    modport slave  (input cmd, input valid, output ready);
endinterface

interface ht_res_if;
    import hash_table::*;

    ht_result_t result;
    logic       valid;
    logic       ready;

    modport master (output result, output valid, input ready);
    modport slave  (input result, input valid, output ready);
endinterface

// File: rtl/ht_cmd_initiator_ts_fifo.sv
// Show-ahead timestamp FIFO; the caller never pushes when full or pops when empty.
module ht_ts_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_i) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_i)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    assign head_o = mem[rd_ptr];

endmodule

// File: rtl/ht_cmd_initiator.sv
// Issues user commands to the hash table, tracks outstanding requests and
// returns results with issue-to-response latency, watchdog and error flags.
module ht_cmd_initiator
    import hash_table::*;
#(
    parameter int unsigned MAX_INFLIGHT = 8,
    parameter int unsigned TIMEOUT      = 1024
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  ht_command_t                   user_cmd_i,
    input  logic                          user_cmd_valid_i,
    output logic                          user_cmd_ready_o,
    ht_cmd_if.master                      ht_cmd_out,
    ht_res_if.slave                       ht_res_in,
    output ht_result_t                    user_res_o,
    output logic [LAT_W-1:0]              user_res_latency_o,
    output logic                          user_res_valid_o,
    input  logic                          user_res_ready_i,
    output logic [$clog2(MAX_INFLIGHT):0] inflight_o,
    output logic                          timeout_o,
    input  logic                          clear_timeout_i,
    output logic                          proto_err_o,
    output logic [31:0]                   cmd_cnt_o,
    output logic [31:0]                   res_cnt_o
);

    localparam int unsigned      CNT_W   = $clog2(MAX_INFLIGHT) + 1;
    localparam int unsigned      WD_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

    logic             not_full_c;
    logic             issue_c;
    logic             res_ready_c;
    logic             accept_c;
    logic             pop_c;
    logic [CNT_W-1:0] inflight_nxt;
    logic [LAT_W-1:0] cycle_cnt;
    logic [LAT_W-1:0] ts_head;
    logic [WD_W-1:0]  wd_cnt;
    logic [WD_W-1:0]  wd_cnt_nxt;
    wd_state_e        state;
    wd_state_e        state_nxt;

    // Combinational issue path, throttled at MAX_INFLIGHT outstanding.
    assign not_full_c       = inflight_o < MAX_CNT;
    assign ht_cmd_out.cmd   = user_cmd_i;
    assign ht_cmd_out.valid = user_cmd_valid_i && not_full_c;
    assign user_cmd_ready_o = ht_cmd_out.ready && not_full_c;
    assign issue_c          = ht_cmd_out.valid && ht_cmd_out.ready;

    assign res_ready_c      = !user_res_valid_o || user_res_ready_i;
    assign ht_res_in.ready  = res_ready_c;
    assign accept_c         = ht_res_in.valid && res_ready_c;
    // An unsolicited response leaves the timestamp FIFO untouched.
    assign pop_c            = accept_c && (inflight_o != '0);

    always_comb begin
        inflight_nxt = inflight_o;
        if (issue_c && !pop_c) begin
            inflight_nxt = inflight_o + CNT_W'(1);
        end else if (pop_c && !issue_c) begin
            inflight_nxt = inflight_o - CNT_W'(1);
        end
    end

    ht_ts_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (LAT_W)
    ) u_ts_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (issue_c),
        .data_i (cycle_cnt),
        .pop_i  (pop_c),
        .head_o (ts_head)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycle_cnt          <= '0;
            inflight_o         <= '0;
            user_res_valid_o   <= 1'b0;
            user_res_o         <= '0;
            user_res_latency_o <= '0;
            proto_err_o        <= 1'b0;
            cmd_cnt_o          <= '0;
            res_cnt_o          <= '0;
            timeout_o          <= 1'b0;
        end else begin
            cycle_cnt  <= cycle_cnt + LAT_W'(1);
            inflight_o <= inflight_nxt;
            timeout_o  <= (state_nxt == WD_TIMEOUT);

            if (accept_c) begin
                user_res_valid_o   <= 1'b1;
                user_res_o         <= ht_res_in.result;
                user_res_latency_o <= pop_c ? LAT_W'(cycle_cnt - ts_head) : '0;
            end else if (user_res_ready_i) begin
                user_res_valid_o <= 1'b0;
            end

            if (accept_c && !pop_c) begin
                proto_err_o <= 1'b1;
            end else if (clear_timeout_i) begin
                proto_err_o <= 1'b0;
            end

            if (issue_c && (cmd_cnt_o != '1))  cmd_cnt_o <= cmd_cnt_o + 32'd1;
            if (accept_c && (res_cnt_o != '1)) res_cnt_o <= res_cnt_o + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= WD_IDLE;
            wd_cnt <= '0;
        end else begin
            state  <= state_nxt;
            wd_cnt <= wd_cnt_nxt;
        end
    end

    // Watchdog: counts cycles since the last issue-from-idle or accepted response.
    always_comb begin
        state_nxt  = state;
        wd_cnt_nxt = wd_cnt;
        unique case (state)
            WD_IDLE: begin
                wd_cnt_nxt = '0;
                if (issue_c) state_nxt = WD_WAIT;
            end
            WD_WAIT: begin
                if (inflight_nxt == '0) begin
                    state_nxt  = WD_IDLE;
                    wd_cnt_nxt = '0;
                end else if (accept_c) begin
                    wd_cnt_nxt = '0;
                end else if (wd_cnt == WD_LAST) begin
                    state_nxt  = WD_TIMEOUT;
                    wd_cnt_nxt = '0;
                end else begin
                    wd_cnt_nxt = wd_cnt + WD_W'(1);
                end
            end
            WD_TIMEOUT: begin
                wd_cnt_nxt = '0;
                if (clear_timeout_i) state_nxt = WD_IDLE;
            end
            default: begin
                state_nxt  = WD_IDLE;
                wd_cnt_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_ht_cmd_initiator.sv
// Directed bench for ht_cmd_initiator with a queue-based reference model.
module tb_ht_cmd_initiator;
    import hash_table::*;

    localparam int unsigned MAXI = 8;
    localparam int unsigned TMO  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    ht_command_t user_cmd;
    logic        ucv;
    logic        ucr;
    ht_result_t  user_res;
    logic [15:0] lat;
    logic        urv;
    logic        urr;
    logic [3:0]  inflight;
    logic        tmo;
    logic        clr;
    logic        proto;
    logic [31:0] cmd_cnt;
    logic [31:0] res_cnt;

    ht_cmd_if cmd_if ();
    ht_res_if res_if ();

    always #5 clk = ~clk;

    ht_cmd_initiator #(.MAX_INFLIGHT(MAXI), .TIMEOUT(TMO)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .user_cmd_i         (user_cmd),
        .user_cmd_valid_i   (ucv),
        .user_cmd_ready_o   (ucr),
        .ht_cmd_out         (cmd_if),
        .ht_res_in          (res_if),
        .user_res_o         (user_res),
        .user_res_latency_o (lat),
        .user_res_valid_o   (urv),
        .user_res_ready_i   (urr),
        .inflight_o         (inflight),
        .timeout_o          (tmo),
        .clear_timeout_i    (clr),
        .proto_err_o        (proto),
        .cmd_cnt_o          (cmd_cnt),
        .res_cnt_o          (res_cnt)
    );

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: outstanding issue cycles in a queue, latency = now - issue.
    int          q[$];
    bit          m_uv, m_proto, m_tmo, m_armed, m_room, m_issue, m_accept, m_empty;
    ht_result_t  m_res;
    logic [15:0] m_lat;
    int          m_cc, m_rc, m_deadline, cyc;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_uv = 0; m_res = '0; m_lat = '0; m_cc = 0; m_rc = 0;
            m_proto = 0; m_tmo = 0; m_armed = 0; m_deadline = 0; cyc = 0;
        end else begin
            m_room = q.size() < MAXI;
            chk("cmd_valid", 128'(cmd_if.valid), 128'(ucv && m_room));
            chk("cmd_ready", 128'(ucr), 128'(cmd_if.ready && m_room));
            chk("cmd_pass", 128'(cmd_if.cmd), 128'(user_cmd));
            chk("res_ready", 128'(res_if.ready), 128'(!m_uv || urr));
            chk("inflight", 128'(inflight), 128'(q.size()));
            chk("res_valid", 128'(urv), 128'(m_uv));
            if (m_uv) begin
                chk("res_data", 128'(user_res), 128'(m_res));
                chk("res_latency", 128'(lat), 128'(m_lat));
            end
            chk("cmd_cnt", 128'(cmd_cnt), 128'(m_cc));
            chk("res_cnt", 128'(res_cnt), 128'(m_rc));
            chk("proto_err", 128'(proto), 128'(m_proto));
            chk("timeout", 128'(tmo), 128'(m_tmo));

            m_issue  = ucv && cmd_if.ready && m_room;
            m_accept = res_if.valid && (!m_uv || urr);
            m_empty  = q.size() == 0;
            if (clr) m_proto = 0;
            if (m_accept) begin
                m_uv  = 1;
                m_res = res_if.result;
                m_rc++;
                if (m_empty) begin
                    m_lat   = '0;
                    m_proto = 1;
                end else begin
                    m_lat = 16'(cyc - q.pop_front());
                end
            end else if (urr) begin
                m_uv = 0;
            end
            if (m_issue) begin
                q.push_back(cyc);
                m_cc++;
            end
            if (m_tmo) begin
                if (clr) begin m_tmo = 0; m_armed = 0; end
            end else if (m_armed) begin
                if (q.size() == 0)        m_armed = 0;
                else if (m_accept)        m_deadline = cyc + TMO;
                else if (cyc == m_deadline) m_tmo = 1;
            end else if (m_issue) begin
                m_armed    = 1;
                m_deadline = cyc + TMO;
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [31:0] key);
        logic acc;
        acc = 1'b0;
        user_cmd = '{opcode: OP_INSERT, key: key, value: key ^ 32'h5A5A_0000};
        ucv = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            acc = ucr;
            step();
            if (acc) break;
        end
        ucv = 1'b0;
        chk("cmd_handshake", 128'(acc), 128'(1));
    endtask

    task automatic send_res(input logic [31:0] val);
        logic acc;
        acc = 1'b0;
        res_if.result = '{status: ST_OK, value: val};
        res_if.valid  = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            acc = res_if.ready;
            step();
            if (acc) break;
        end
        res_if.valid = 1'b0;
        chk("res_handshake", 128'(acc), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int n_issued;
        ucv = 0; user_cmd = '0; urr = 1; clr = 0;
        cmd_if.ready = 1; res_if.valid = 0; res_if.result = '0;
        repeat (3) step();
        chk("rst_res_valid", 128'(urv), 128'(0));
        chk("rst_inflight", 128'(inflight), 128'(0));
        chk("rst_cmd_cnt", 128'(cmd_cnt), 128'(0));
        chk("rst_timeout", 128'(tmo), 128'(0));
        chk("rst_latency", 128'(lat), 128'(0));
        rst = 0;
        step();

        // Single command, response 5 cycles after issue.
        send_cmd(32'd1);
        chk("s1_inflight1", 128'(inflight), 128'(1));
        repeat (4) step();
        send_res(32'd100);
        chk("s1_latency", 128'(lat), 128'(5));
        chk("s1_inflight0", 128'(inflight), 128'(0));
        chk("s1_cmd_cnt", 128'(cmd_cnt), 128'(1));
        chk("s1_res_cnt", 128'(res_cnt), 128'(1));
        chk("s1_value", 128'(user_res.value), 128'(100));
        step();

        // Ten back-to-back commands against an eight-deep window.
        n_issued = 0;
        ucv = 1;
        for (int i = 0; i < 10; i++) begin
            user_cmd.key = 32'(i + 16);
            n_issued += int'(ucr);
            step();
        end
        ucv = 0;
        chk("s2_issued", 128'(n_issued), 128'(8));
        chk("s2_ready_full", 128'(ucr), 128'(0));
        chk("s2_inflight8", 128'(inflight), 128'(8));
        send_res(32'd200);
        chk("s2_ready_back", 128'(ucr), 128'(1));
        chk("s2_inflight7", 128'(inflight), 128'(7));
        for (int i = 0; i < 7; i++) send_res(32'(201 + i));
        step();

        // Issue and response in the same cycle at inflight 3.
        for (int i = 0; i < 3; i++) send_cmd(32'(40 + i));
        user_cmd.key = 32'd43;
        ucv = 1;
        res_if.result = '{status: ST_NOT_FOUND, value: 32'd250};
        res_if.valid = 1;
        step();
        ucv = 0;
        res_if.valid = 0;
        chk("s3_inflight3", 128'(inflight), 128'(3));
        for (int i = 0; i < 3; i++) send_res(32'(251 + i));
        step();

        // Output back-pressure for four cycles.
        send_cmd(32'd60);
        send_cmd(32'd61);
        urr = 0;
        send_res(32'd300);
        fork
            send_res(32'd301);
            begin
                for (int i = 0; i < 4; i++) begin
                    chk("s4_res_ready_low", 128'(res_if.ready), 128'(0));
                    chk("s4_res_stable", 128'(user_res.value), 128'(300));
                    step();
                end
                urr = 1;
            end
        join
        chk("s4_second_value", 128'(user_res.value), 128'(301));
        chk("s4_inflight0", 128'(inflight), 128'(0));
        step();

        // Watchdog expiry, clear and late response.
        clr = 1;
        step();
        clr = 0;
        send_cmd(32'd70);
        repeat (15) step();
        chk("s5_tmo_before", 128'(tmo), 128'(0));
        step();
        chk("s5_tmo_rise", 128'(tmo), 128'(1));
        clr = 1;
        step();
        clr = 0;
        chk("s5_tmo_clear", 128'(tmo), 128'(0));
        send_res(32'd500);
        chk("s5_late_latency", 128'(lat), 128'(18));
        step();

        // Unsolicited response, then reset in the middle of a burst.
        send_res(32'd600);
        chk("s6_proto", 128'(proto), 128'(1));
        chk("s6_latency0", 128'(lat), 128'(0));
        chk("s6_inflight0", 128'(inflight), 128'(0));
        urr = 0;
        ucv = 1;
        step();
        step();
        rst = 1;
        #1;
        chk("r_res_valid", 128'(urv), 128'(0));
        chk("r_res_data", 128'(user_res), 128'(0));
        chk("r_latency", 128'(lat), 128'(0));
        chk("r_inflight", 128'(inflight), 128'(0));
        chk("r_timeout", 128'(tmo), 128'(0));
        chk("r_proto", 128'(proto), 128'(0));
        chk("r_cmd_cnt", 128'(cmd_cnt), 128'(0));
        chk("r_res_cnt", 128'(res_cnt), 128'(0));
        ucv = 0;
        urr = 1;
        step();
        step();
        rst = 0;
        step();
        send_res(32'd700);
        chk("s7_proto", 128'(proto), 128'(1));
        chk("s7_latency0", 128'(lat), 128'(0));
        send_cmd(32'd80);
        repeat (2) step();
        send_res(32'd701);
        chk("s7_latency3", 128'(lat), 128'(3));
        repeat (3) step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ht_cmd_initiator.md
HT_CMD_INITIATOR -- requirements
Module: ht_cmd_initiator

Interface
REQ-001 Parameters: MAX_INFLIGHT, default 8, power of two, maximum outstanding commands; TIMEOUT, default 1024, watchdog cycles without a response.
REQ-002 clk_i  input  1  single clock, all logic rising-edge.
REQ-003 rst_i  input  1  asynchronous, active-high reset.
REQ-004 user_cmd_i  input  ht_command_t  command (opcode, key, value) from user.
REQ-005 user_cmd_valid_i / user_cmd_ready_o  input / output  1  user command handshake.
REQ-006 ht_cmd_out  ht_cmd_if.master  --  command toward hash table (cmd, valid, ready).
REQ-007 ht_res_in  ht_res_if.slave  --  result from hash table (result struct, valid, ready).
REQ-008 user_res_o  output  ht_result_t  registered result to user.
REQ-009 user_res_latency_o  output  16  issue-to-response cycles for user_res_o.
REQ-010 user_res_valid_o / user_res_ready_i  output / input  1  user result handshake.
REQ-011 inflight_o  output  $clog2(MAX_INFLIGHT)+1  outstanding command count.
REQ-012 timeout_o  output  1  sticky watchdog flag; clear_timeout_i  input  1  clears it.
REQ-013 proto_err_o  output  1  sticky flag, response received with zero outstanding; cleared by clear_timeout_i.
REQ-014 cmd_cnt_o, res_cnt_o  output  32  saturating issued/received counters.

Function
REQ-015 Issue path is combinational: ht_cmd_out.cmd = user_cmd_i; ht_cmd_out.valid = user_cmd_valid_i && inflight < MAX_INFLIGHT; user_cmd_ready_o = ht_cmd_out.ready && inflight < MAX_INFLIGHT.
REQ-016 A command is issued on a cycle with ht_cmd_out.valid && ht_cmd_out.ready; the 16-bit free-running cycle counter value is pushed into the timestamp FIFO on that cycle.
REQ-017 The hash table returns results in order; each accepted response pops one timestamp.
REQ-018 user_res_latency_o = cycle counter minus popped timestamp, modulo 2^16; wrap of the counter needs no special handling.
REQ-019 Response path is a 1-deep output register: ht_res_in.ready = !user_res_valid_o || user_res_ready_i; a response is accepted when ht_res_in.valid && ht_res_in.ready and appears on user_res_o the next cycle.
REQ-020 user_res_valid_o stays high with stable data until user_res_ready_i.
REQ-021 inflight: +1 on issue, -1 on accepted response, unchanged when both occur in the same cycle; it never exceeds MAX_INFLIGHT, because issue is blocked at full.
REQ-022 A response accepted with inflight == 0 is forwarded with latency 0; proto_err_o is set, inflight stays 0, and the FIFO is not popped.
REQ-023 Watchdog FSM states:
- IDLE: inflight == 0; counter cleared. Goes to WAIT on issue.
- WAIT: counter increments each cycle; cleared on every accepted response. Goes to IDLE when inflight reaches 0; goes to TIMEOUT when counter == TIMEOUT-1.
- TIMEOUT: timeout_o = 1. Goes to IDLE on clear_timeout_i.
REQ-024 A response arriving in TIMEOUT is still processed normally.
REQ-025 cmd_cnt_o/res_cnt_o increment on issue/accept and hold at 0xFFFFFFFF.

Reset
REQ-026 Asynchronous reset (rst_i high) sets all of the following to 0: user_res_valid_o, user_res_o, user_res_latency_o, inflight_o, timeout_o, proto_err_o, cmd_cnt_o, res_cnt_o, the cycle counter and the FIFO pointers. The FSM goes to IDLE.
REQ-027 Reset mid-operation discards all outstanding timestamps; responses after reset are handled per REQ-022.

Structure
REQ-028 ht_command_t and ht_result_t come from package hash_table; the latency width (16) is a localparam there.
REQ-029 The timestamp FIFO is one sub-module, ht_ts_fifo (depth MAX_INFLIGHT, width 16, show-ahead); everything else is flat.

Verification
REQ-030 Single command, hash table responds 5 cycles after issue -> user_res_latency_o = 5, inflight 1->0, cmd_cnt = res_cnt = 1.
REQ-031 10 back-to-back commands with responses withheld -> exactly 8 issued, user_cmd_ready_o = 0, inflight_o = 8; one response restores ready within 1 cycle.
REQ-032 Issue and response in the same cycle with inflight = 3 -> inflight stays 3, latencies correct.
REQ-033 user_res_ready_i held low for 4 cycles -> ht_res_in.ready = 0, user_res_o stable, no result lost.
REQ-034 TIMEOUT = 16, one command with no response -> timeout_o rises 16 cycles after issue; clear_timeout_i -> 0; a late response gives latency > 16.
REQ-035 Unsolicited response with inflight = 0 -> proto_err_o = 1, latency 0, inflight_o = 0; rst_i asserted mid-burst -> all outputs 0 immediately.
